// File: rtl/onchip_copy_pkg.sv
// Shared constants and types for the on-chip memory copy master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onchip_copy_pkg;

    localparam int DEPTH  = 32000;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 64;
    localparam int CHUNK  = 4;

    localparam logic [DATA_W/8-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_WR,
        ST_FIN
    } state_t;

    localparam logic [1:0] STATUS_OK    = 2'd0;
    localparam logic [1:0] STATUS_PARAM = 2'd1;
    localparam logic [1:0] STATUS_ABORT = 2'd2;

endpackage

// File: rtl/copy_chunk_buffer.sv
// Small register file holding one chunk of words between the read and write phases.
// Latency: write lands on the next clock edge; read is combinational from the index.
// Backpressure: none; the owning FSM sequences every access.
module copy_chunk_buffer #(
    parameter int CHUNK  = 4,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [CHUNK];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM master copying a word block inside a single-port memory, chunk by chunk.
// Latency: done in cycle t + 2*len + ceil(len/CHUNK) + 1 after start (t+1 on a parameter error).
// Backpressure: none; the memory accepts one access per cycle, start is ignored while busy.
module onchip_memory_copy_master
    import onchip_copy_pkg::*;
#(
    parameter int DEPTH  = onchip_copy_pkg::DEPTH,
    parameter int ADDR_W = onchip_copy_pkg::ADDR_W,
    parameter int DATA_W = onchip_copy_pkg::DATA_W,
    parameter int CHUNK  = onchip_copy_pkg::CHUNK
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W-1:0]   len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int IDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int CW    = $clog2(CHUNK) + 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [CW-1:0]   CHUNK_C = CW'(CHUNK);

    state_t            state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] rem_after;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     k;
    logic              param_err;
    logic              last_beat;
    logic              buf_wr_en;
    logic [IDX_W-1:0]  buf_wr_idx;
    logic [IDX_W-1:0]  buf_rd_idx;
    logic [DATA_W-1:0] buf_rd_dat;

    function automatic logic [CW-1:0] chunk_of(input logic [ADDR_W-1:0] words);
        return (words >= ADDR_W'(CHUNK)) ? CHUNK_C : CW'(words);
    endfunction

    always_comb begin
        param_err  = (len == '0)
                  || (({1'b0, src_addr} + {1'b0, len}) > DEPTH_X)
                  || (({1'b0, dst_addr} + {1'b0, len}) > DEPTH_X);
        last_beat  = (cnt == k - 1'b1);
        rem_after  = remaining - ADDR_W'(k);
        // Read data trails its address by one cycle, so slot i fills one cycle after read i.
        buf_wr_en  = ((state == ST_RD) && (cnt != '0)) || (state == ST_LAT);
        buf_wr_idx = (state == ST_LAT) ? IDX_W'(k - 1'b1) : IDX_W'(cnt - 1'b1);
        buf_rd_idx = (state == ST_WR) ? IDX_W'(cnt + 1'b1) : '0;
    end

    copy_chunk_buffer #(
        .CHUNK  (CHUNK),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (buf_wr_en),
        .wr_idx (buf_wr_idx),
        .wr_dat (readdata),
        .rd_idx (buf_rd_idx),
        .rd_dat (buf_rd_dat)
    );

    assign clken = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            src        <= '0;
            dst        <= '0;
            remaining  <= '0;
            cnt        <= '0;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= STATUS_OK;
            address    <= '0;
            byteenable <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
        end else begin
            done <= 1'b0;
            if (abort && ((state == ST_RD) || (state == ST_LAT) || (state == ST_WR))) begin
                state      <= ST_FIN;
                chipselect <= 1'b0;
                write      <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                status     <= STATUS_ABORT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (param_err) begin
                                state  <= ST_FIN;
                                done   <= 1'b1;
                                status <= STATUS_PARAM;
                            end else begin
                                state      <= ST_RD;
                                busy       <= 1'b1;
                                status     <= STATUS_OK;
                                src        <= src_addr;
                                dst        <= dst_addr;
                                remaining  <= len;
                                k          <= chunk_of(len);
                                cnt        <= '0;
                                address    <= src_addr;
                                byteenable <= (DATA_W/8)'(BE_ALL);
                                chipselect <= 1'b1;
                                write      <= 1'b0;
                            end
                        end
                    end
                    ST_RD: begin
                        if (last_beat) begin
                            state      <= ST_LAT;
                            chipselect <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            address <= address + 1'b1;
                        end
                    end
                    ST_LAT: begin
                        state      <= ST_WR;
                        chipselect <= 1'b1;
                        write      <= 1'b1;
                        address    <= dst;
                        // A one-word chunk is still being captured this cycle, so forward it.
                        writedata  <= (k == CW'(1)) ? readdata : buf_rd_dat;
                    end
                    ST_WR: begin
                        if (last_beat) begin
                            src       <= src + ADDR_W'(k);
                            dst       <= dst + ADDR_W'(k);
                            remaining <= rem_after;
                            cnt       <= '0;
                            write     <= 1'b0;
                            if (rem_after == '0) begin
                                state      <= ST_FIN;
                                chipselect <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                state   <= ST_RD;
                                address <= src + ADDR_W'(k);
                                k       <= chunk_of(rem_after);
                            end
                        end else begin
                            cnt       <= cnt + 1'b1;
                            address   <= address + 1'b1;
                            writedata <= buf_rd_dat;
                        end
                    end
                    ST_FIN: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onchip_memory_copy_master.sv
// Scoreboard bench: memory model with one-cycle read latency, queues of expected accesses and completions.
module tb_onchip_memory_copy_master;

    localparam int DEPTH = 32000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [14:0] src_addr;
    logic [14:0] dst_addr;
    logic [14:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [14:0] address;
    logic [7:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [63:0] writedata;
    logic        clken;
    logic [63:0] readdata;

    onchip_memory_copy_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken),
        .readdata   (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input int a);
        return 64'hA5A5_0000_0000_0000 + 64'(a) - 64'd100;
    endfunction

    // Memory model: registered address, unregistered data out.
    logic [63:0] mem [DEPTH];
    logic [14:0] addr_q = '0;
    logic        fill_req = 1'b0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= pat(a);
        end else if (chipselect && clken) begin
            if (write) mem[address] <= writedata;
            addr_q <= address;
        end
    end
    assign readdata = mem[addr_q];

    typedef struct packed {
        logic [14:0] addr;
        logic [63:0] dat;
    } wr_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  st;
    } dn_t;

    logic [14:0] exp_rd [$];
    wr_t         exp_wr [$];
    dn_t         exp_dn [$];

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every bus access and every completion is matched against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (chipselect && !write) begin
                chk("read_expected", exp_rd.size() != 0, 64'(address), 64'(exp_rd.size()));
                if (exp_rd.size() != 0) begin
                    logic [14:0] ea;
                    ea = exp_rd.pop_front();
                    chk("read_addr", address == ea, 64'(address), 64'(ea));
                    chk("read_be", byteenable == 8'hFF, 64'(byteenable), 64'hFF);
                end
            end
            if (chipselect && write) begin
                chk("write_expected", exp_wr.size() != 0, 64'(address), 64'(exp_wr.size()));
                if (exp_wr.size() != 0) begin
                    wr_t ew;
                    ew = exp_wr.pop_front();
                    chk("write_addr", address == ew.addr, 64'(address), 64'(ew.addr));
                    chk("write_data", writedata == ew.dat, writedata, ew.dat);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", exp_dn.size() != 0, 64'(cyc), 64'(exp_dn.size()));
                if (exp_dn.size() != 0) begin
                    dn_t ed;
                    ed = exp_dn.pop_front();
                    chk("done_cycle", cyc == ed.cyc, 64'(cyc), 64'(ed.cyc));
                    chk("status", status == ed.st, 64'(status), 64'(ed.st));
                    chk("busy_at_done", busy == 1'b0, 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic push_copy(input int s, input int d, input int nrd, input int nwr);
        for (int i = 0; i < nrd; i++) exp_rd.push_back(15'(s + i));
        for (int i = 0; i < nwr; i++) exp_wr.push_back('{addr: 15'(d + i), dat: pat(s + i)});
    endtask

    // Drives one start pulse; t is the cycle in which start is presented.
    task automatic issue(input int s, input int d, input int l, input logic ab,
                         input int lat, input logic [1:0] st, input bit want_done);
        int t;
        @(posedge clk);
        #1;
        src_addr = 15'(s);
        dst_addr = 15'(d);
        len      = 15'(l);
        abort    = ab;
        start    = 1'b1;
        t        = int'(cyc);
        if (want_done) exp_dn.push_back('{cyc: 32'(t + lat), st: st});
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != base) break;
        end
        chk("done_seen", done_cnt != base, 64'(done_cnt), 64'(base + 1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
        chk("rst_done", done == 1'b0, 64'(done), 64'd0);
        chk("rst_status", status == 2'd0, 64'(status), 64'd0);
        chk("rst_chipselect", chipselect == 1'b0, 64'(chipselect), 64'd0);
        chk("rst_write", write == 1'b0, 64'(write), 64'd0);
        chk("rst_address", address == 15'd0, 64'(address), 64'd0);
        chk("rst_byteenable", byteenable == 8'd0, 64'(byteenable), 64'd0);
        chk("rst_writedata", writedata == 64'd0, writedata, 64'd0);
        chk("rst_clken", clken == 1'b1, 64'(clken), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        fill_req = 1'b1;
        @(posedge clk);
        #1;
        fill_req = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals();
        reset_n = 1'b1;

        // Ten words in chunks 4,4,2: done at t+24.
        push_copy(100, 2000, 10, 10);
        issue(100, 2000, 10, 1'b0, 24, 2'd0, 1'b1);
        chk("busy_after_start", busy == 1'b1, 64'(busy), 64'd1);
        wait_done(60);
        for (int i = 0; i < 10; i++)
            chk("dst_word", mem[2000 + i] == pat(100 + i), mem[2000 + i], pat(100 + i));

        // Single word to the top of memory.
        push_copy(0, 31999, 1, 1);
        issue(0, 31999, 1, 1'b0, 4, 2'd0, 1'b1);
        wait_done(20);
        chk("top_word", mem[31999] == pat(0), mem[31999], pat(0));

        // Parameter errors: no access, done at t+1.
        issue(5, 6, 0, 1'b0, 1, 2'd1, 1'b1);
        wait_done(10);
        issue(31990, 10, 20, 1'b0, 1, 2'd1, 1'b1);
        wait_done(10);
        issue(10, 31999, 2, 1'b0, 1, 2'd1, 1'b1);
        wait_done(10);

        // Abort in the second write cycle of the first chunk.
        push_copy(1000, 3000, 4, 2);
        issue(1000, 3000, 8, 1'b0, 8, 2'd2, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(20);
        chk("abort_word1", mem[3001] == pat(1001), mem[3001], pat(1001));
        chk("abort_word2_untouched", mem[3002] == pat(3002), mem[3002], pat(3002));

        // Asynchronous reset during the read phase of a 12-word copy.
        push_copy(500, 600, 2, 0);
        issue(500, 600, 12, 1'b0, 0, 2'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_copy(700, 800, 4, 4);
        issue(700, 800, 4, 1'b0, 10, 2'd0, 1'b1);
        wait_done(30);
        for (int i = 0; i < 4; i++)
            chk("post_reset_word", mem[800 + i] == pat(700 + i), mem[800 + i], pat(700 + i));

        // start+abort in IDLE runs; a start while busy is ignored.
        push_copy(300, 400, 5, 5);
        issue(300, 400, 5, 1'b1, 13, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        src_addr = 15'd0;
        dst_addr = 15'd10;
        len      = 15'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_start_ignored", mem[10] == pat(10), mem[10], pat(10));

        chk("reads_drained", exp_rd.size() == 0, 64'(exp_rd.size()), 64'd0);
        chk("writes_drained", exp_wr.size() == 0, 64'(exp_wr.size()), 64'd0);
        chk("dones_drained", exp_dn.size() == 0, 64'(exp_dn.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
